// File: rtl/roll_pkg.sv
// Shared types and helpers for the dice-roll sequencer.
// Stage intervals double per stage, starting from the base period.
package roll_pkg;

  localparam int RAND_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Computed at 64 bits so callers can detect overflow before truncating.
  function automatic logic [63:0] stage_interval(input logic [63:0] base, input logic [7:0] stage);
    return base << stage;
  endfunction

endpackage

// File: rtl/roll_interval_timer.sv
// Free-running interval counter: ticks combinationally on the last count of
// each interval and wraps to zero; clear restarts the interval.
module roll_interval_timer #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_interval,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_match;

  assign w_match = (r_cnt == i_interval - CNT_W'(1));
  assign o_tick  = i_enable && w_match;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || o_tick) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/roll_sequencer.sv
// Drives LFSR advance pulses at a slowing cadence, mirrors each new value to
// the display, then freezes on the final value and pulses o_done.
module roll_sequencer
  import roll_pkg::*;
#(
  parameter int BASE_PERIOD     = 2500000,
  parameter int STEPS_PER_STAGE = 8,
  parameter int N_STAGES        = 4,
  parameter int CNT_W           = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [RAND_W-1:0] i_rand,
  output logic              o_advance,
  output logic [RAND_W-1:0] o_random,
  output logic              o_busy,
  output logic              o_done
);

  localparam int STEP_W  = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE) : 1;
  localparam int STAGE_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [63:0] MAX_IV = stage_interval(64'(BASE_PERIOD), 8'(N_STAGES - 1));

  if (BASE_PERIOD < 2 || STEPS_PER_STAGE < 1 || N_STAGES < 1 || (MAX_IV >> CNT_W) != 64'd0) begin : g_param_err
    $error("roll_sequencer: bad parameters or slowest interval does not fit in CNT_W");
  end

  state_t              r_state, w_next_state;
  logic [STEP_W-1:0]   r_step;
  logic [STAGE_W-1:0]  r_stage;
  logic                r_adv_d;
  logic [RAND_W-1:0]   r_random;
  logic [CNT_W-1:0]    w_interval;
  logic                w_tick;
  logic                w_last_step;
  logic                w_last_stage;
  logic                w_restart;

  assign w_interval   = CNT_W'(stage_interval(64'(BASE_PERIOD), 8'(r_stage)));
  assign w_last_step  = (r_step == STEP_W'(STEPS_PER_STAGE - 1));
  assign w_last_stage = (r_stage == STAGE_W'(N_STAGES - 1));
  assign w_restart    = i_start && (r_state == IDLE || r_state == RUN);

  roll_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_restart || r_state != RUN),
    .i_enable   (r_state == RUN),
    .i_interval (w_interval),
    .o_tick     (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (i_start) w_next_state = RUN;
      RUN: begin
        if (i_start) begin
          w_next_state = RUN;
        end else if (i_stop || (w_tick && w_last_step && w_last_stage)) begin
          w_next_state = LATCH;
        end
      end
      LATCH:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_advance = (r_state == RUN) && w_tick;
    o_busy    = (r_state == RUN);
    o_done    = (r_state == LATCH);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_restart) begin
      r_step  <= '0;
      r_stage <= '0;
    end else if (o_advance) begin
      if (w_last_step) begin
        r_step  <= '0;
        r_stage <= w_last_stage ? '0 : r_stage + STAGE_W'(1);
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  // The LFSR output lags its enable by a cycle, so sample one cycle after advance.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_adv_d  <= 1'b0;
      r_random <= '0;
    end else begin
      r_adv_d <= o_advance;
      if (r_adv_d || r_state == LATCH) begin
        r_random <= i_rand;
      end
    end
  end

  assign o_random = r_random;

endmodule

// File: tb/tb_roll_sequencer.sv
// Directed bench for roll_sequencer with a small LFSR driving i_rand.
// BASE_PERIOD=2, STEPS=2, N_STAGES=3: advances at RUN cycles 1,3,7,11,19,27.
module tb_roll_sequencer;

  logic       clk = 1'b0;
  logic       i_reset, i_start, i_stop;
  logic [3:0] i_rand;
  logic       o_advance, o_busy, o_done;
  logic [3:0] o_random;
  logic       lfsr_seed;
  int         checks = 0;
  int         errors = 0;

  // LFSR values after successive steps from seed 4'h1 with next = {x[2:0], x[3]^x[2]}.
  logic [3:0] seq [0:8] = '{4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lfsr_seed) i_rand <= 4'h1;
    else if (o_advance) i_rand <= {i_rand[2:0], i_rand[3] ^ i_rand[2]};
  end

  roll_sequencer #(
    .BASE_PERIOD(2), .STEPS_PER_STAGE(2), .N_STAGES(3), .CNT_W(8)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_rand(i_rand), .o_advance(o_advance), .o_random(o_random),
    .o_busy(o_busy), .o_done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reseed the LFSR, then start a roll; returns at RUN cycle 0.
  task automatic start_roll();
    lfsr_seed = 1'b1;
    step();
    lfsr_seed = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Walks RUN cycles 0..n, pulsing start/stop at the given cycles, and checks
  // advance against a hand-derived mask, done/busy, and the display value
  // (which shows the k-th LFSR value two cycles after the k-th advance).
  task automatic run_win(input string name, input int n, input int start_c, input int stop_c,
                         input logic [63:0] adv_mask, input int done_c, input logic [3:0] prev);
    for (int c = 0; c <= n; c++) begin
      int k;
      logic [3:0] exp_r;
      i_start = (c == start_c);
      i_stop  = (c == stop_c);
      k = 0;
      for (int a = 0; a < 64; a++) if (adv_mask[a] && a + 2 <= c) k++;
      exp_r = (k == 0) ? prev : seq[k-1];
      chk($sformatf("%s adv@%0d", name, c), 32'(o_advance), 32'(adv_mask[c]));
      chk($sformatf("%s done@%0d", name, c), 32'(o_done), 32'(c == done_c));
      chk($sformatf("%s busy@%0d", name, c), 32'(o_busy), 32'(c < done_c));
      chk($sformatf("%s rand@%0d", name, c), 32'(o_random), 32'(exp_r));
      step();
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  initial begin
    logic [63:0] m_full, m_rr, m_sim;
    m_full = (64'd1 << 1) | (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 11) | (64'd1 << 19) | (64'd1 << 27);
    m_rr   = (64'd1 << 1) | (64'd1 << 3) | (64'd1 << 7) | (m_full << 10);
    m_sim  = (64'd1 << 1) | (64'd1 << 3) | (m_full << 5);

    i_reset = 1'b1; i_start = 1'b1; i_stop = 1'b1; lfsr_seed = 1'b1;
    step();
    step();
    i_reset = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst adv", 32'(o_advance), 32'd0);
    chk("rst rand", 32'(o_random), 32'd0);

    start_roll();
    run_win("full", 29, -1, -1, m_full, 28, 4'd0);

    start_roll();
    run_win("estop", 8, -1, 4, (64'd1 << 1) | (64'd1 << 3), 5, 4'd13);

    start_roll();
    run_win("stopadv", 7, -1, 3, (64'd1 << 1) | (64'd1 << 3), 4, 4'd4);

    start_roll();
    run_win("reroll", 40, 9, -1, m_rr, 38, 4'd4);

    start_roll();
    run_win("simul", 35, 4, 4, m_sim, 33, 4'd11);

    start_roll();
    run_win("latchstart", 31, 28, 30, m_full, 28, 4'd5);

    start_roll();
    for (int c = 0; c < 5; c++) step();
    chk("mid busy", 32'(o_busy), 32'd1);
    i_reset = 1'b1; i_start = 1'b1;
    step();
    i_reset = 1'b0; i_start = 1'b0;
    chk("midrst busy", 32'(o_busy), 32'd0);
    chk("midrst rand", 32'(o_random), 32'd0);
    chk("midrst adv", 32'(o_advance), 32'd0);
    chk("midrst done", 32'(o_done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post rst idle adv@%0d", c), 32'(o_advance), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/roll_sequencer.md
Name: roll_sequencer

Overview:
Controller for the 4-bit LFSR random-number source. On a start request it issues advance pulses to the LFSR at a slowing cadence (a "rolling dice" effect), mirroring each new value to the display register. It then freezes on a final value and reports completion. Sits between the debounced key inputs and the LFSR/seven-segment path.

Parameters:
BASE_PERIOD, 2500000, clock cycles between advances in stage 0 (must be >=2)
STEPS_PER_STAGE, 8, advance pulses issued per stage (>=1)
N_STAGES, 4, number of stages; stage s interval = BASE_PERIOD << s
CNT_W, 32, width of interval counter (must hold BASE_PERIOD << (N_STAGES-1))

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset  input  1  reset, synchronous, active-high
i_start  input  1  single-cycle start/re-roll request (debounced key)
i_stop  input  1  single-cycle early-stop request
i_rand  input  4  current LFSR output
o_advance  output  1  one-cycle enable to LFSR step input
o_random  output  4  displayed value
o_busy  output  1  high while rolling (RUN state)
o_done  output  1  one-cycle pulse when the final value is latched

Behaviour:
- Reset (i_reset=1 at edge): state=IDLE; counter, stage, and step=0; o_random=0; o_advance=0; o_busy=0; o_done=0. Reset wins over all simultaneous inputs.
- States: IDLE, RUN, LATCH.
- IDLE:
  - i_start=1 -> RUN, with counter, stage, and step=0.
  - i_stop is ignored.
  - o_random holds.
- RUN:
  - o_busy=1. Counter increments each cycle.
  - o_advance=1 (combinational from state/counter) exactly when counter == (BASE_PERIOD<<stage)-1; that cycle the counter clears to 0 and step increments.
  - When an advance occurs with step==STEPS_PER_STAGE-1: step=0, stage increments. If stage==N_STAGES-1, go to LATCH instead.
  - Display update: the cycle after every o_advance, o_random <= i_rand, because the LFSR output lags its enable by one cycle.
  - Total advances per roll = N_STAGES*STEPS_PER_STAGE. First advance occurs in RUN cycle BASE_PERIOD-1 (0-based).
- LATCH (one cycle): o_random <= i_rand (final post-advance value), o_done=1, then IDLE. o_busy=0.
- i_start in RUN: restart, with counter, stage, and step=0; stay in RUN; no o_done. If it coincides with an advance cycle, the advance still pulses and the display update still occurs next cycle.
- i_stop in RUN: go to LATCH next cycle, with no further advances. If it coincides with an advance cycle, the advance pulses and LATCH captures the resulting value.
- i_start and i_stop together in RUN: i_start wins.
- i_start in LATCH: ignored; the FSM returns to IDLE.
- Interval arithmetic is done in CNT_W bits. Shift overflow is a parameter error; an elaboration-time assertion is required.

Decomposition:
- Package roll_pkg: state enum (IDLE, RUN, LATCH), RAND_W=4, and a function for the stage interval.
- Sub-module roll_interval_timer:
  - Inputs: clear, enable, interval.
  - Output: tick.
  - Holds the CNT_W counter.
- Top holds the FSM, the stage/step counters, and the display register.

Test Plan:
- Reset mid-RUN (BASE_PERIOD=2, STEPS=2, N_STAGES=3): assert i_reset at RUN cycle 5 -> next cycle IDLE, o_random=0, o_busy=0, o_advance=0.
- Full roll, same params, LFSR model connected:
  - i_start -> o_advance at RUN cycles 1,3,7,11,19,27 (6 pulses).
  - RUN lasts 28 cycles, then LATCH: o_done=1 for 1 cycle, o_random equals LFSR value after the 6th step.
- Display tracking: after each o_advance, o_random matches i_rand the next cycle; it is unchanged on all other cycles.
- Early stop: i_stop at RUN cycle 4 -> no advance at cycle 7; o_done at cycle 5; o_random equals the value after the 2nd step.
- Re-roll: i_start at RUN cycle 9 -> counters restart, next advance at cycle 11 (9+2), full 6-pulse schedule from there, no intermediate o_done.
- Simultaneous events: i_start+i_stop together in RUN -> restart only; i_start during LATCH -> ignored, IDLE reached, o_done pulse still emitted once.
